// File: rtl/snake_ram_reader_pkg.sv
// Shared definitions for the snake segment RAM reader.
// Holds segment word field positions, segment type codes, colour constants,
// screen dimensions, the decoded segment struct, the reader FSM state type
// and a helper that splits a raw RAM word into its fields.
package snake_ram_reader_pkg;

  // Segment word layout: {type[1:0], x[7:0], y[6:0]}
  localparam int TYPE_MSB = 16;
  localparam int TYPE_LSB = 15;
  localparam int X_MSB    = 14;
  localparam int X_LSB    = 7;
  localparam int Y_MSB    = 6;
  localparam int Y_LSB    = 0;
  localparam int SEG_W    = 17;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_FOOD = 2'b10;
  localparam logic [1:0] T_RSVD = 2'b11;

  localparam logic [2:0] COL_HEAD  = 3'b010;
  localparam logic [2:0] COL_BODY  = 3'b100;
  localparam logic [2:0] COL_FOOD  = 3'b001;
  localparam logic [2:0] COL_ERASE = 3'b000;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

  typedef struct packed {
    logic [1:0] typ;
    logic [7:0] x;
    logic [6:0] y;
  } seg_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_LATCH,
    S_DRAW,
    S_NEXT,
    S_FINISH
  } state_t;

  function automatic seg_t seg_decode(input logic [SEG_W-1:0] w);
    seg_t s;
    s.typ = w[TYPE_MSB:TYPE_LSB];
    s.x   = w[X_MSB:X_LSB];
    s.y   = w[Y_MSB:Y_LSB];
    return s;
  endfunction

endpackage

// File: rtl/snake_ram_reader_if.sv
// Reader bus: segment RAM read port plus the VGA pixel stream.
// master: the reader (drives rd_address and the pixel stream).
// slave:  the RAM/VGA side (returns rd_q, consumes pixels).
interface snake_ram_reader_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] rd_address;
  logic [16:0]       rd_q;
  logic              plot;
  logic [7:0]        x;
  logic [6:0]        y;
  logic [2:0]        colour;

  modport master (output rd_address, input rd_q, output plot, x, y, colour);
  modport slave  (input rd_address, output rd_q, input plot, x, y, colour);
endinterface

// File: rtl/snake_block_raster.sv
// Combinational block rasteriser.
// Inputs:  base_x/base_y (segment origin), pc (pixel counter, dy:dx).
// Outputs: px/py (pixel position), clip (pixel falls outside the screen).
// Sums are widened by one bit so a block hanging off the right/bottom edge
// is clipped rather than wrapping back onto the screen.
module snake_block_raster #(
  parameter int BLOCK_LOG2 = 1,
  parameter int SCR_W      = 160,
  parameter int SCR_H      = 120
) (
  input  logic [7:0]              base_x,
  input  logic [6:0]              base_y,
  input  logic [2*BLOCK_LOG2-1:0] pc,
  output logic [7:0]              px,
  output logic [6:0]              py,
  output logic                    clip
);
  logic [8:0] x9;
  logic [7:0] y8;

  assign x9   = {1'b0, base_x} + 9'(pc[BLOCK_LOG2-1:0]);
  assign y8   = {1'b0, base_y} + 8'(pc[2*BLOCK_LOG2-1:BLOCK_LOG2]);
  assign px   = x9[7:0];
  assign py   = y8[6:0];
  assign clip = (x9 >= 9'(SCR_W)) || (y8 >= 8'(SCR_H));
endmodule

// File: rtl/snake_ram_reader.sv
// Walks snake segment RAM entries 0..length-1 and draws each segment as a
// BLOCK x BLOCK square on the VGA pixel stream.
// Ports: clk, reset_n (async low), go/erase/length (start request, sampled
// in IDLE), bus (RAM read port + pixel stream, master side), busy (not
// IDLE), done (one-cycle pulse after the pass, coincides with busy falling).
module snake_ram_reader
  import snake_ram_reader_pkg::*;
#(
  parameter int         ADDR_W     = 11,
  parameter int         BLOCK_LOG2 = 1,
  parameter int         RD_LAT     = 1,
  parameter int         SCR_W      = SCR_W_DEF,
  parameter int         SCR_H      = SCR_H_DEF,
  parameter logic [2:0] HEAD_COL   = COL_HEAD,
  parameter logic [2:0] BODY_COL   = COL_BODY,
  parameter logic [2:0] FOOD_COL   = COL_FOOD
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                go,
  input  logic                erase,
  input  logic [ADDR_W-1:0]   length,
  snake_ram_reader_if.master  bus,
  output logic                busy,
  output logic                done
);
  localparam int PC_W = 2 * BLOCK_LOG2;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, len_q, rd_addr_q;
  logic              erase_q;
  seg_t              seg_q, seg_in;
  logic [PC_W-1:0]   pc_q;
  logic [1:0]        wait_q;
  logic              plot_q, done_q;
  logic [7:0]        x_q, px;
  logic [6:0]        y_q, py;
  logic [2:0]        col_q, pix_col;
  logic              clip, last_idx;

  assign seg_in   = seg_decode(bus.rd_q);
  assign last_idx = (idx_q == len_q - ADDR_W'(1));

  snake_block_raster #(
    .BLOCK_LOG2(BLOCK_LOG2),
    .SCR_W     (SCR_W),
    .SCR_H     (SCR_H)
  ) u_raster (
    .base_x(seg_q.x),
    .base_y(seg_q.y),
    .pc    (pc_q),
    .px    (px),
    .py    (py),
    .clip  (clip)
  );

  always_comb begin
    pix_col = COL_ERASE;
    if (!erase_q) begin
      case (seg_q.typ)
        T_HEAD:  pix_col = HEAD_COL;
        T_BODY:  pix_col = BODY_COL;
        T_FOOD:  pix_col = FOOD_COL;
        default: pix_col = COL_ERASE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (go) state_d = (length == '0) ? S_FINISH : S_FETCH;
      S_FETCH:  state_d = (RD_LAT > 1) ? S_WAIT : S_LATCH;
      // Holds for RD_LAT-1 cycles so rd_q is valid when LATCH samples it
      S_WAIT:   if (wait_q == 2'(RD_LAT - 2)) state_d = S_LATCH;
      S_LATCH:  state_d = (seg_in.typ == T_RSVD) ? S_NEXT : S_DRAW;
      S_DRAW:   if (&pc_q) state_d = S_NEXT;
      S_NEXT:   state_d = last_idx ? S_FINISH : S_FETCH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q     <= '0;
      len_q     <= '0;
      rd_addr_q <= '0;
      erase_q   <= 1'b0;
      seg_q     <= '0;
      pc_q      <= '0;
      wait_q    <= '0;
      plot_q    <= 1'b0;
      done_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      col_q     <= '0;
    end else begin
      plot_q <= 1'b0;
      done_q <= (state_q == S_FINISH);
      case (state_q)
        S_IDLE: if (go) begin
          len_q     <= length;
          erase_q   <= erase;
          idx_q     <= '0;
          rd_addr_q <= '0;
        end
        S_FETCH: wait_q <= '0;
        S_WAIT:  wait_q <= wait_q + 2'd1;
        S_LATCH: begin
          seg_q <= seg_in;
          pc_q  <= '0;
        end
        // Clipped pixels still take their cycle; only the strobe is masked
        S_DRAW: begin
          plot_q <= !clip;
          x_q    <= px;
          y_q    <= py;
          col_q  <= pix_col;
          pc_q   <= pc_q + PC_W'(1);
        end
        S_NEXT: if (!last_idx) begin
          idx_q     <= idx_q + ADDR_W'(1);
          rd_addr_q <= idx_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.rd_address = rd_addr_q;
  assign bus.plot       = plot_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = col_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;
endmodule

// File: tb/tb_snake_ram_reader.sv
// Bench for snake_ram_reader: two instances (RD_LAT=1 and RD_LAT=2) share the
// control inputs and segment memory; each has its own RAM latency model.
// A reference model derived from the segment rules predicts pixels, done
// timing and the highest address read.
module tb_snake_ram_reader;
  localparam int BLOCK = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go, erase;
  logic [10:0] length;
  logic        busy1, done1, busy2, done2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snake_ram_reader_if #(.ADDR_W(11)) bus1 ();
  snake_ram_reader_if #(.ADDR_W(11)) bus2 ();

  snake_ram_reader #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .go(go), .erase(erase), .length(length),
    .bus(bus1), .busy(busy1), .done(done1));

  snake_ram_reader #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .go(go), .erase(erase), .length(length),
    .bus(bus2), .busy(busy2), .done(done2));

  // Segment memory with 1- and 2-cycle synchronous read paths
  logic [16:0] mem [64];
  logic [16:0] q1_a, q2_a, q2_b;
  always @(posedge clk) begin
    q1_a <= mem[bus1.rd_address[5:0]];
    q2_a <= mem[bus2.rd_address[5:0]];
    q2_b <= q2_a;
  end
  assign bus1.rd_q = q1_a;
  assign bus2.rd_q = q2_b;

  // Output monitors
  logic [17:0] pix1 [$];
  logic [17:0] pix2 [$];
  int          addr1 [$];
  int          addr2 [$];
  int          dcnt1 = 0, dcnt2 = 0;
  always @(negedge clk) begin
    if (bus1.plot) pix1.push_back({bus1.x, bus1.y, bus1.colour});
    if (bus2.plot) pix2.push_back({bus2.x, bus2.y, bus2.colour});
    if (done1) dcnt1++;
    if (done2) dcnt2++;
    addr1.push_back(int'(bus1.rd_address));
    addr2.push_back(int'(bus2.rd_address));
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] mk(input int t, input int xx, input int yy);
    logic [1:0] tt;
    logic [7:0] xv;
    logic [6:0] yv;
    tt = 2'(t); xv = 8'(xx); yv = 7'(yy);
    return {tt, xv, yv};
  endfunction

  function automatic logic [2:0] model_col(input int t, input bit er);
    if (er) return 3'b000;
    case (t)
      0: return 3'b100;
      1: return 3'b010;
      2: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Reference pixel list
  logic [17:0] exp_q [$];
  task automatic build_exp(input int len, input bit er);
    exp_q.delete();
    for (int e = 0; e < len; e++) begin
      int t, bx, by;
      t  = int'(mem[e][16:15]);
      bx = int'(mem[e][14:7]);
      by = int'(mem[e][6:0]);
      if (t != 3) begin
        for (int dy = 0; dy < BLOCK; dy++)
          for (int dx = 0; dx < BLOCK; dx++) begin
            int px, py;
            logic [7:0] xv;
            logic [6:0] yv;
            px = bx + dx; py = by + dy;
            xv = 8'(px); yv = 7'(py);
            if (px < 160 && py < 120) exp_q.push_back({xv, yv, model_col(t, er)});
          end
      end
    end
  endtask

  // Per entry: fetch, read wait, latch, next, plus BLOCK^2 draw cycles unless
  // reserved; finish and the registered done add two.
  function automatic int exp_cycles(input int len, input int lat);
    int c;
    c = 2;
    for (int e = 0; e < len; e++)
      c += 3 + (lat - 1) + ((mem[e][16:15] == 2'b11) ? 0 : BLOCK * BLOCK);
    return c;
  endfunction

  task automatic cmp_pix(input string tag, input int base, input int which);
    int n;
    n = (which == 1) ? pix1.size() - base : pix2.size() - base;
    check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < n)
        check({tag, "_pix"}, 32'((which == 1) ? pix1[base + i] : pix2[base + i]),
              32'(exp_q[i]));
  endtask

  task automatic run_pass(input string tag, input int len, input bit er, input bit retrig);
    int b1, b2, d1, d2, a1, a2, c1, c2, cnt, mx1, mx2;
    build_exp(len, er);
    b1 = pix1.size(); b2 = pix2.size(); d1 = dcnt1; d2 = dcnt2;
    c1 = -1; c2 = -1;
    @(posedge clk); #1;
    go = 1'b1; erase = er; length = 11'(len);
    @(posedge clk); #1;
    go = 1'b0; erase = 1'($urandom); length = 11'($urandom);
    a1 = addr1.size(); a2 = addr2.size();
    cnt = 1;
    check({tag, "_busy_start"}, 32'(busy1), 32'(1));
    while ((c1 < 0 || c2 < 0) && cnt < 2000) begin
      if (done1 && c1 < 0) begin c1 = cnt; check({tag, "_busy_at_done1"}, 32'(busy1), 0); end
      if (done2 && c2 < 0) begin c2 = cnt; check({tag, "_busy_at_done2"}, 32'(busy2), 0); end
      go = retrig && (cnt == 3);
      @(posedge clk); #1;
      cnt++;
    end
    go = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_done_cyc1"}, 32'(c1), 32'(exp_cycles(len, 1)));
    check({tag, "_done_cyc2"}, 32'(c2), 32'(exp_cycles(len, 2)));
    check({tag, "_done_cnt1"}, 32'(dcnt1 - d1), 32'(1));
    check({tag, "_done_cnt2"}, 32'(dcnt2 - d2), 32'(1));
    check({tag, "_idle1"}, 32'(busy1), 0);
    cmp_pix({tag, "_d1"}, b1, 1);
    cmp_pix({tag, "_d2"}, b2, 2);
    mx1 = 0; mx2 = 0;
    for (int i = a1; i < addr1.size(); i++) if (addr1[i] > mx1) mx1 = addr1[i];
    for (int i = a2; i < addr2.size(); i++) if (addr2[i] > mx2) mx2 = addr2[i];
    check({tag, "_max_addr1"}, 32'(mx1), 32'((len == 0) ? 0 : len - 1));
    check({tag, "_max_addr2"}, 32'(mx2), 32'((len == 0) ? 0 : len - 1));
  endtask

  initial begin
    int d1, d2, k;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset_n = 1'b0; go = 1'b0; erase = 1'b0; length = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot",   32'(bus1.plot), 0);
    check("rst_x",      32'(bus1.x), 0);
    check("rst_y",      32'(bus1.y), 0);
    check("rst_colour", 32'(bus1.colour), 0);
    check("rst_addr",   32'(bus1.rd_address), 0);
    check("rst_busy",   32'({busy1, busy2}), 0);
    check("rst_done",   32'({done1, done2}), 0);
    reset_n = 1'b1;

    mem[0] = mk(1, 20, 10);
    mem[1] = mk(0, 20, 11);
    run_pass("basic", 2, 1'b0, 1'b0);
    check("basic_cyc_const", 32'(exp_cycles(2, 1)), 32'(16));
    run_pass("erase", 2, 1'b1, 1'b0);
    run_pass("retrig", 2, 1'b0, 1'b1);
    run_pass("after_done", 2, 1'b0, 1'b0);

    mem[0] = mk(0, 159, 119);
    run_pass("clip", 1, 1'b0, 1'b0);
    run_pass("len0", 0, 1'b0, 1'b0);
    mem[0] = mk(3, 40, 40);
    run_pass("rsvd", 1, 1'b0, 1'b0);

    // Reset while drawing
    mem[0] = mk(1, 20, 10);
    mem[1] = mk(0, 20, 11);
    d1 = dcnt1; d2 = dcnt2;
    @(posedge clk); #1;
    go = 1'b1; erase = 1'b0; length = 11'd2;
    @(posedge clk); #1;
    go = 1'b0;
    k = 0;
    while (!bus1.plot && k < 100) begin @(negedge clk); k++; end
    check("rst_mid_reached_draw", 32'(bus1.plot), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_plot", 32'({bus1.plot, bus2.plot}), 0);
    check("rst_mid_busy", 32'({busy1, busy2}), 0);
    check("rst_mid_done", 32'({done1, done2}), 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_no_done", 32'((dcnt1 - d1) + (dcnt2 - d2)), 0);
    check("rst_mid_idle", 32'({busy1, busy2}), 0);
    run_pass("post_rst", 2, 1'b0, 1'b0);

    // Randomised passes with edge-biased coordinates
    for (int r = 0; r < 12; r++) begin
      int len;
      for (int e = 0; e < 8; e++) begin
        int t, xx, yy;
        t  = $urandom_range(0, 3);
        xx = ($urandom_range(0, 3) == 0) ? $urandom_range(155, 255) : $urandom_range(0, 159);
        yy = ($urandom_range(0, 3) == 0) ? $urandom_range(115, 127) : $urandom_range(0, 119);
        mem[e] = mk(t, xx, yy);
      end
      len = $urandom_range(0, 8);
      run_pass("rand", len, 1'($urandom), (len > 0) ? 1'($urandom) : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/snake_ram_reader.md
Name: snake_ram_reader

Overview:
- Read-side companion to the snake segment RAM.
- On a `go` pulse it walks segment entries 0..length-1, decodes each 17-bit word as {type[1:0], x[7:0], y[6:0]}, and draws a BLOCK×BLOCK square per segment.
- Output is a pixel stream (plot, x, y, colour) for the VGA adapter; colour depends on segment type or erase mode.
- Sits between the segment RAM's read port and the VGA adapter; the game FSM triggers it once per frame after the RAM update completes.

Parameters:
- ADDR_W, 11, segment RAM address width.
- BLOCK_LOG2, 1, log2 of drawn block edge (1 → 2×2 pixels).
- RD_LAT, 1, cycles from rd_address valid to rd_q valid (1 or 2).
- SCR_W, 160, screen width in pixels; x ≥ SCR_W is clipped.
- SCR_H, 120, screen height in pixels; y ≥ SCR_H is clipped.
- HEAD_COL, 3'b010, colour for type 01.
- BODY_COL, 3'b100, colour for type 00.
- FOOD_COL, 3'b001, colour for type 10.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- go, input, 1, single-cycle start request; sampled only in IDLE.
- erase, input, 1, sampled with go; when 1, all plotted pixels use colour 3'b000.
- length, input, ADDR_W, number of entries to read; sampled with go.
- rd_address, output, ADDR_W, RAM read address.
- rd_q, input, 17, RAM read data.
- plot, output, 1, pixel write strobe.
- x, output, 8, pixel x.
- y, output, 7, pixel y.
- colour, output, 3, pixel colour.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse at end of a pass.

Behaviour:
- Clocking and reset: one clock domain, clk. reset_n is asynchronous and active-low.
- Reset values: state=IDLE; rd_address=0, plot=0, x=0, y=0, colour=0, busy=0, done=0; all internal registers 0.
- Reset asserted mid-pass aborts the pass immediately; no done pulse is produced.
- States: IDLE, FETCH, WAIT, LATCH, DRAW, NEXT, FINISH.
- IDLE:
  - go=1 with length≠0 → FETCH. Latch length and erase; set idx=0 and rd_address=0.
  - go=1 with length=0 → FINISH directly.
- FETCH: hold rd_address=idx; go to WAIT.
- WAIT: count RD_LAT-1 cycles. RD_LAT=1 means zero cycles here, so FETCH goes straight to LATCH.
- LATCH:
  - Register rd_q into seg_type, seg_x, seg_y.
  - Clear pixel counter pc (2*BLOCK_LOG2 bits).
  - Type 11 (reserved) → NEXT without drawing; otherwise → DRAW.
- DRAW, one pixel per cycle, BLOCK² cycles total:
  - x = seg_x + pc[BLOCK_LOG2-1:0]; y = seg_y + pc[2*BLOCK_LOG2-1:BLOCK_LOG2]. Pixels go in row-major order, dx fastest.
  - Offsets are computed at 9/8 bits before comparing with SCR_W/SCR_H.
  - plot=1 unless the pixel is clipped; a clipped pixel still consumes its cycle.
  - colour = 0 if erase, else the colour for seg_type.
  - After the pixel with pc = all-ones → NEXT.
- Output timing: plot/x/y/colour are registered and valid in the cycle following the DRAW-state cycle that produced them. plot is 0 in every other cycle.
- NEXT:
  - idx = length-1 → FINISH.
  - Otherwise idx+1 → FETCH with rd_address=idx+1.
- FINISH: done=1 for one cycle → IDLE. busy drops in the same cycle as return to IDLE.
- go while busy is ignored: no restart and no corruption of the pass.
- length and erase changing mid-pass have no effect.
- idx wraps never: length is at most 2^ADDR_W, checked against the latched value.
- Cycles per pass (RD_LAT=1, no reserved entries): length*(3+BLOCK²)+2 from go to done, excluding the go cycle.

Decomposition:
- Shared game package holds:
  - segment field positions: TYPE_MSB=16, TYPE_LSB=15, X_MSB=14, X_LSB=7, Y_MSB=6, Y_LSB=0;
  - type codes: T_BODY=2'b00, T_HEAD=2'b01, T_FOOD=2'b10, T_RSVD=2'b11;
  - colour constants;
  - screen dimensions.
- One natural sub-module, snake_block_raster: given base x/y and pc, produces pixel x/y plus a clip flag. It is combinational and instantiated once.
- The FSM, counters and output registers stay in snake_ram_reader.

Test Plan:
- Basic draw: RAM[0]={01,20,10}, RAM[1]={00,20,11}; go with length=2, erase=0, BLOCK_LOG2=1.
  - Expect 8 plot pulses: (20,10),(21,10),(20,11),(21,11) with colour 010, then (20,11),(21,11),(20,12),(21,12) with colour 100.
  - Expect done exactly 2*(3+4)+2=16 cycles after go.
- Erase: same RAM, go with erase=1 → same 8 coordinates, all with colour 000.
- Clipping: RAM[0]={00,159,119} → only (159,119) is plotted. The three clipped cycles have plot=0; done timing is unchanged.
- Boundary cases:
  - length=0 → no plot and no RAM read beyond address 0; done 2 cycles after go.
  - RAM[0] type 11 with length=1 → zero plots; done 5 cycles after go.
- Re-trigger: go pulsed again 3 cycles into a length=2 pass → pass completes unchanged with a single done pulse. A go issued after done starts a fresh pass.
- Reset mid-pass and read latency:
  - Deassert reset_n during DRAW → plot, busy and done all go to 0 immediately, asynchronously. After release, the block is in IDLE and a new go works.
  - Repeat the basic draw with RD_LAT=2 → same pixels, 2 extra cycles total.
